// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host command path.
package ps2_pkg;

   typedef enum logic [2:0] {
      IDLE,
      INHIBIT,
      REQ,
      SEND,
      IDLE_WAIT,
      RESP,
      FINISH
   } state_t;

   localparam logic [7:0] ACK    = 8'hFA;
   localparam logic [7:0] RESEND = 8'hFE;

   localparam logic [1:0] ERR_OK     = 2'd0;
   localparam logic [1:0] ERR_CLK_TO = 2'd1;
   localparam logic [1:0] ERR_NO_ACK = 2'd2;
   localparam logic [1:0] ERR_RESP   = 2'd3;

   // One shared cycle counter serves all three wait phases, so size it for the longest.
   function automatic int cnt_width(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Three-flop synchronisers for the PS/2 clock and data pins with clock falling-edge detect.
// Edge is flagged 2-3 cycles after the pin falls; levels come from the last stage.
module ps2_line_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic clk_pin,
   input  logic data_pin,
   output logic clk_lvl,
   output logic data_lvl,
   output logic clk_fall
);

   logic [2:0] clk_sync;
   logic [2:0] data_sync;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clk_sync  <= 3'b111;
         data_sync <= 3'b111;
      end else begin
         clk_sync  <= {clk_sync[1:0], clk_pin};
         data_sync <= {data_sync[1:0], data_pin};
      end
   end

   assign clk_fall = ~clk_sync[1] & clk_sync[2];
   assign clk_lvl  = clk_sync[2];
   assign data_lvl = data_sync[2];

endmodule

// File: rtl/ps2_cmd_ctrl.sv
// PS/2 host-to-keyboard command sender: inhibit, request-to-send, 11-clock frame, ACK and response check.
// One command in flight; cmd_valid is only taken in IDLE, retries on 0xFE up to MAX_RETRY.
module ps2_cmd_ctrl
   import ps2_pkg::*;
#(
   parameter int INHIBIT_CYC = 5000,
   parameter int CLK_TO_CYC  = 750000,
   parameter int RESP_TO_CYC = 1000000,
   parameter int MAX_RETRY   = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cmd_valid,
   input  logic [7:0] cmd_byte,
   output logic       cmd_ready,
   input  logic       ps2k_clk_in,
   input  logic       ps2k_data_in,
   output logic       ps2k_clk_oe,
   output logic       ps2k_data_oe,
   input  logic [7:0] rx_byte,
   input  logic       rx_valid,
   output logic       rx_inhibit,
   output logic       done,
   output logic       err,
   output logic [1:0] err_code
);

   localparam int CW = cnt_width(INHIBIT_CYC, CLK_TO_CYC, RESP_TO_CYC);

   state_t        state;
   logic [CW-1:0] cnt;
   logic [3:0]    edge_cnt;
   logic [9:0]    sh;
   logic [7:0]    cmd_q;
   logic [3:0]    retry;
   logic          clk_lvl;
   logic          data_lvl;
   logic          clk_fall;
   logic          fin;
   logic [1:0]    fin_code;

   ps2_line_sync u_sync (
      .clk      (clk),
      .rst_n    (rst_n),
      .clk_pin  (ps2k_clk_in),
      .data_pin (ps2k_data_in),
      .clk_lvl  (clk_lvl),
      .data_lvl (data_lvl),
      .clk_fall (clk_fall)
   );

   // Every way a transaction can end, success or failure, funnels through fin.
   always_comb begin
      fin      = 1'b0;
      fin_code = ERR_OK;
      case (state)
         SEND: begin
            if (clk_fall) begin
               if (edge_cnt == 4'd10 && data_lvl) begin
                  fin      = 1'b1;
                  fin_code = ERR_NO_ACK;
               end
            end else if (cnt == CW'(CLK_TO_CYC - 1)) begin
               fin      = 1'b1;
               fin_code = ERR_CLK_TO;
            end
         end
         IDLE_WAIT: begin
            if (!(clk_lvl && data_lvl) && !clk_fall && cnt == CW'(CLK_TO_CYC - 1)) begin
               fin      = 1'b1;
               fin_code = ERR_CLK_TO;
            end
         end
         RESP: begin
            if (rx_valid) begin
               if (rx_byte == ACK) begin
                  fin = 1'b1;
               end else if (!(rx_byte == RESEND && retry < 4'(MAX_RETRY))) begin
                  fin      = 1'b1;
                  fin_code = ERR_RESP;
               end
            end else if (cnt == CW'(RESP_TO_CYC - 1)) begin
               fin      = 1'b1;
               fin_code = ERR_RESP;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         cmd_ready    <= 1'b1;
         ps2k_clk_oe  <= 1'b0;
         ps2k_data_oe <= 1'b0;
         rx_inhibit   <= 1'b0;
         done         <= 1'b0;
         err          <= 1'b0;
         err_code     <= ERR_OK;
         retry        <= '0;
         cnt          <= '0;
         edge_cnt     <= '0;
         sh           <= '0;
         cmd_q        <= '0;
      end else begin
         done <= 1'b0;
         if (fin) begin
            state        <= FINISH;
            ps2k_clk_oe  <= 1'b0;
            ps2k_data_oe <= 1'b0;
            rx_inhibit   <= 1'b0;
            done         <= 1'b1;
            err          <= (fin_code != ERR_OK);
            err_code     <= fin_code;
         end else begin
            case (state)
               IDLE: begin
                  if (cmd_valid && cmd_ready) begin
                     cmd_q       <= cmd_byte;
                     retry       <= '0;
                     err         <= 1'b0;
                     err_code    <= ERR_OK;
                     cmd_ready   <= 1'b0;
                     ps2k_clk_oe <= 1'b1;
                     rx_inhibit  <= 1'b1;
                     cnt         <= '0;
                     state       <= INHIBIT;
                  end
               end
               INHIBIT: begin
                  if (cnt == CW'(INHIBIT_CYC - 1)) begin
                     ps2k_clk_oe  <= 1'b0;
                     ps2k_data_oe <= 1'b1;
                     state        <= REQ;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               REQ: begin
                  sh       <= {1'b1, ~^cmd_q, cmd_q};
                  edge_cnt <= '0;
                  cnt      <= '0;
                  state    <= SEND;
               end
               SEND: begin
                  if (clk_fall) begin
                     cnt      <= '0;
                     edge_cnt <= edge_cnt + 4'd1;
                     if (edge_cnt == 4'd10) begin
                        state <= IDLE_WAIT;
                     end else begin
                        ps2k_data_oe <= ~sh[0];
                        sh           <= {1'b0, sh[9:1]};
                     end
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               IDLE_WAIT: begin
                  if (clk_lvl && data_lvl) begin
                     rx_inhibit <= 1'b0;
                     cnt        <= '0;
                     state      <= RESP;
                  end else if (clk_fall) begin
                     cnt <= '0;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               RESP: begin
                  if (rx_valid && rx_byte == RESEND) begin
                     retry       <= retry + 4'd1;
                     ps2k_clk_oe <= 1'b1;
                     rx_inhibit  <= 1'b1;
                     cnt         <= '0;
                     state       <= INHIBIT;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               FINISH: begin
                  cmd_ready <= 1'b1;
                  state     <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ps2_cmd_ctrl.sv
// Directed bench for ps2_cmd_ctrl with a behavioural keyboard on the open-collector lines.
`timescale 1ns/1ps
module tb_ps2_cmd_ctrl;

   localparam int INH     = 40;
   localparam int CLK_TO  = 3000;
   localparam int RESP_TO = 4000;
   localparam int MAXR    = 2;
   localparam int HALF    = 20;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       cmd_valid = 1'b0;
   logic [7:0] cmd_byte = 8'h00;
   logic       cmd_ready;
   logic       clk_oe, data_oe;
   logic [7:0] rx_byte = 8'h00;
   logic       rx_valid = 1'b0;
   logic       rx_inhibit, done, err;
   logic [1:0] err_code;
   logic       kb_clk = 1'b1, kb_data = 1'b1;
   logic       clk_line, data_line;

   assign clk_line  = ~clk_oe & kb_clk;
   assign data_line = ~data_oe & kb_data;

   always #5 clk = ~clk;

   ps2_cmd_ctrl #(
      .INHIBIT_CYC (INH),
      .CLK_TO_CYC  (CLK_TO),
      .RESP_TO_CYC (RESP_TO),
      .MAX_RETRY   (MAXR)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .cmd_valid    (cmd_valid),
      .cmd_byte     (cmd_byte),
      .cmd_ready    (cmd_ready),
      .ps2k_clk_in  (clk_line),
      .ps2k_data_in (data_line),
      .ps2k_clk_oe  (clk_oe),
      .ps2k_data_oe (data_oe),
      .rx_byte      (rx_byte),
      .rx_valid     (rx_valid),
      .rx_inhibit   (rx_inhibit),
      .done         (done),
      .err          (err),
      .err_code     (err_code)
   );

   int n_checks = 0;
   int n_fail = 0;
   int cyc = 0;
   int frames = 0, inh_run = 0, last_inh = 0;
   bit inh_prev = 1'b0;
   bit done_seen = 1'b0;
   logic done_err;
   logic [1:0] done_code;
   int done_cyc = 0, done_cnt = 0, t_stop = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Frame count and inhibit width are taken from clk_oe; done pulses are latched.
   always @(negedge clk) begin
      if (clk_oe === 1'b1) begin
         if (!inh_prev) begin
            frames++;
            inh_run = 1;
         end else begin
            inh_run++;
         end
      end else if (inh_prev) begin
         last_inh = inh_run;
      end
      inh_prev = (clk_oe === 1'b1);
      if (done === 1'b1) begin
         done_seen = 1'b1;
         done_err  = err;
         done_code = err_code;
         done_cyc  = cyc;
         done_cnt++;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic send_cmd(input logic [7:0] b);
      int t;
      t = 0;
      @(negedge clk);
      while (cmd_ready !== 1'b1 && t < 20000) begin
         @(negedge clk);
         t++;
      end
      chk("ready_before_cmd", cmd_ready, 1);
      done_seen = 1'b0;
      cmd_byte  = b;
      cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   // Keyboard side of a host-to-device frame; stop_after>0 freezes the clock low after that edge.
   task automatic kb_frame(input int stop_after, input bit do_ack,
                           output logic [7:0] b, output logic par, output logic stp);
      int t;
      b = 8'h00; par = 1'b0; stp = 1'b0;
      t = 0;
      while (clk_line && t < 2000) begin
         @(negedge clk);
         t++;
      end
      t = 0;
      while (!(clk_line && !data_line) && t < 2000) begin
         @(negedge clk);
         t++;
      end
      chk("request_to_send", {31'd0, clk_line && !data_line}, 1);
      repeat (10) @(negedge clk);
      for (int e = 1; e <= 11; e++) begin
         kb_clk = 1'b0;
         if (e == stop_after) t_stop = cyc;
         repeat (HALF) @(negedge clk);
         if (e <= 8) b[e-1] = data_line;
         else if (e == 9) par = data_line;
         else if (e == 10) stp = data_line;
         if (e == stop_after) return;
         if (e == 10 && do_ack) kb_data = 1'b0;
         kb_clk = 1'b1;
         repeat (HALF) @(negedge clk);
      end
      kb_data = 1'b1;
   endtask

   task automatic respond(input logic [7:0] r);
      repeat (30) @(negedge clk);
      rx_byte  = r;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic wait_done(input int bound, output bit seen);
      int t;
      t = 0;
      while (!done_seen && t < bound) begin
         @(negedge clk);
         t++;
      end
      seen      = done_seen;
      done_seen = 1'b0;
   endtask

   typedef struct packed {
      logic [7:0]      cmd;
      logic            par;
      logic [1:0]      nresp;
      logic [2:0][7:0] resp;
      logic [1:0]      nframes;
      logic            err;
      logic [1:0]      code;
   } vec_t;

   vec_t vecs [6];

   initial begin
      logic [7:0] b;
      logic       p, s;
      bit         seen;
      int         f0, d0, lat;

      vecs[0] = '{cmd: 8'hED, par: 1'b1, nresp: 2'd1, resp: {8'h00, 8'h00, 8'hFA}, nframes: 2'd1, err: 1'b0, code: 2'd0};
      vecs[1] = '{cmd: 8'hF4, par: 1'b0, nresp: 2'd2, resp: {8'h00, 8'hFA, 8'hFE}, nframes: 2'd2, err: 1'b0, code: 2'd0};
      vecs[2] = '{cmd: 8'hFF, par: 1'b1, nresp: 2'd3, resp: {8'hFE, 8'hFE, 8'hFE}, nframes: 2'd3, err: 1'b1, code: 2'd3};
      vecs[3] = '{cmd: 8'hF3, par: 1'b1, nresp: 2'd1, resp: {8'h00, 8'h00, 8'hAA}, nframes: 2'd1, err: 1'b1, code: 2'd3};
      vecs[4] = '{cmd: 8'h00, par: 1'b1, nresp: 2'd1, resp: {8'h00, 8'h00, 8'hFA}, nframes: 2'd1, err: 1'b0, code: 2'd0};
      vecs[5] = '{cmd: 8'h01, par: 1'b0, nresp: 2'd0, resp: {8'h00, 8'h00, 8'h00}, nframes: 2'd1, err: 1'b1, code: 2'd3};

      #2 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_clk_oe", clk_oe, 0);
      chk("rst_data_oe", data_oe, 0);
      chk("rst_rx_inhibit", rx_inhibit, 0);
      chk("rst_done", done, 0);
      chk("rst_err", {29'd0, err, err_code}, 0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      for (int v = 0; v < 6; v++) begin
         f0 = frames;
         d0 = done_cnt;
         send_cmd(vecs[v].cmd);
         chk($sformatf("v%0d_busy", v), cmd_ready, 0);
         for (int f = 0; f < int'(vecs[v].nframes); f++) begin
            kb_frame(0, 1'b1, b, p, s);
            chk($sformatf("v%0d_f%0d_byte", v, f), b, vecs[v].cmd);
            chk($sformatf("v%0d_f%0d_parity", v, f), p, vecs[v].par);
            chk($sformatf("v%0d_f%0d_stop", v, f), s, 1);
            chk($sformatf("v%0d_f%0d_inhibit_len", v, f), last_inh, INH);
            if (f < int'(vecs[v].nresp)) respond(vecs[v].resp[f]);
         end
         wait_done(RESP_TO + 500, seen);
         chk($sformatf("v%0d_done_seen", v), seen, 1);
         chk($sformatf("v%0d_err", v), done_err, vecs[v].err);
         chk($sformatf("v%0d_err_code", v), done_code, vecs[v].code);
         chk($sformatf("v%0d_frames", v), frames - f0, vecs[v].nframes);
         repeat (20) @(negedge clk);
         chk($sformatf("v%0d_done_once", v), done_cnt - d0, 1);
         chk($sformatf("v%0d_err_held", v), {29'd0, err, err_code}, {29'd0, vecs[v].err, vecs[v].code});
         chk($sformatf("v%0d_released", v), {29'd0, clk_oe, data_oe, rx_inhibit}, 0);
         chk($sformatf("v%0d_ready_after", v), cmd_ready, 1);
      end

      // Keyboard stops clocking after edge 5: host must give up after CLK_TO cycles.
      send_cmd(8'hED);
      kb_frame(5, 1'b1, b, p, s);
      chk("clkto_data_driven", data_oe, 1);
      wait_done(CLK_TO + 500, seen);
      chk("clkto_done_seen", seen, 1);
      chk("clkto_err_code", {30'd0, done_err, done_code}, {30'd0, 1'b1, 2'd1});
      lat = done_cyc - t_stop;
      chk("clkto_latency", {31'd0, lat >= CLK_TO + 1 && lat <= CLK_TO + 5}, 1);
      chk("clkto_released", {30'd0, clk_oe, data_oe}, 0);
      kb_clk = 1'b1;
      repeat (10) @(negedge clk);

      // No ACK on the eleventh clock.
      send_cmd(8'hF4);
      kb_frame(0, 1'b0, b, p, s);
      wait_done(500, seen);
      chk("nack_done_seen", seen, 1);
      chk("nack_err_code", {30'd0, done_err, done_code}, {30'd0, 1'b1, 2'd2});
      repeat (10) @(negedge clk);

      // cmd_valid and rx_valid while the frame is on the wire must be ignored.
      f0 = frames;
      d0 = done_cnt;
      send_cmd(8'hED);
      fork
         kb_frame(0, 1'b1, b, p, s);
         begin
            repeat (120) @(negedge clk);
            chk("busy_not_ready", cmd_ready, 0);
            cmd_byte  = 8'h55;
            cmd_valid = 1'b1;
            rx_byte   = 8'hFA;
            rx_valid  = 1'b1;
            @(negedge clk);
            cmd_valid = 1'b0;
            rx_valid  = 1'b0;
         end
      join
      chk("busy_byte", b, 8'hED);
      chk("busy_no_early_done", done_cnt - d0, 0);
      respond(8'hFA);
      wait_done(500, seen);
      chk("busy_done", {30'd0, seen, done_err}, {30'd0, 1'b1, 1'b0});
      repeat (300) @(negedge clk);
      chk("busy_frames", frames - f0, 1);

      // Asynchronous reset during the frame, just after edge 4.
      send_cmd(8'h00);
      kb_frame(4, 1'b1, b, p, s);
      chk("rst_mid_driving", {30'd0, data_oe, rx_inhibit}, {30'd0, 1'b1, 1'b1});
      #2 rst_n = 1'b0;
      #1;
      chk("rst_mid_oe", {30'd0, clk_oe, data_oe}, 0);
      chk("rst_mid_ready", cmd_ready, 1);
      chk("rst_mid_inhibit", rx_inhibit, 0);
      kb_clk = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
